// File: rtl/uart_rx_param.sv
// UART receiver with runtime frame format, 2-of-3 majority bit sampling,
// valid/ready output holding the word and its error flags, sticky overrun.
module uart_rx_param #(
  parameter int unsigned CLK_HZ = 25000000,
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic [3:0]        data_len,
  input  logic              parity_en,
  input  logic              parity_type,
  input  logic [1:0]        stop_bits,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              break_det,
  output logic              overrun,
  output logic              busy
);
  localparam int unsigned LEN_W = 4;

  if (DATA_W < 5 || DATA_W > 9 || CLK_HZ == 0) begin : g_param_check
    $error("uart_rx_param: DATA_W must be 5..9 and CLK_HZ nonzero");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   cnt, cnt_n;
  logic               rx_m, rx_s, rx_d;
  logic               samp_lo, samp_lo_n, samp_mid, samp_mid_n;
  logic [DIV_W-1:0]   div_l, div_l_n;
  logic [LEN_W-1:0]   len_l, len_l_n, bit_idx, bit_idx_n;
  logic               par_en_l, par_en_l_n, par_type_l, par_type_l_n;
  logic [1:0]         stop_l, stop_l_n;
  logic               stop_idx, stop_idx_n;
  logic [DATA_W-1:0]  shift, shift_n;
  logic               par_acc, par_acc_n, zero_acc, zero_acc_n;
  logic               ferr_acc, ferr_acc_n, brk_acc, brk_acc_n;
  logic [DATA_W-1:0]  m_data_n;
  logic               m_valid_n, parity_err_n, frame_err_n, break_det_n;
  logic               overrun_n, busy_n;

  logic               fall_c, vote_c, at_vote_c, at_end_c, done_c, accept_c;
  logic [DIV_W-1:0]   mid_c, mid_m1_c, mid_p1_c;
  logic [LEN_W-1:0]   len_clamp_c;

  // Two-flop synchronizer plus one delay stage for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall_c    = rx_d & ~rx_s;
  assign mid_c     = div_l >> 1;
  assign mid_m1_c  = mid_c - DIV_W'(1);
  assign mid_p1_c  = mid_c + DIV_W'(1);
  assign at_vote_c = (cnt == mid_p1_c);
  assign at_end_c  = (cnt == div_l);
  assign vote_c    = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);
  assign accept_c  = m_valid & m_ready;

  always_comb begin
    if (data_len < LEN_W'(5))              len_clamp_c = LEN_W'(5);
    else if (data_len > LEN_W'(DATA_W))    len_clamp_c = LEN_W'(DATA_W);
    else                                   len_clamp_c = data_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      samp_lo    <= 1'b1;
      samp_mid   <= 1'b1;
      div_l      <= '0;
      len_l      <= '0;
      bit_idx    <= '0;
      par_en_l   <= 1'b0;
      par_type_l <= 1'b0;
      stop_l     <= '0;
      stop_idx   <= 1'b0;
      shift      <= '0;
      par_acc    <= 1'b0;
      zero_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      brk_acc    <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      samp_lo    <= samp_lo_n;
      samp_mid   <= samp_mid_n;
      div_l      <= div_l_n;
      len_l      <= len_l_n;
      bit_idx    <= bit_idx_n;
      par_en_l   <= par_en_l_n;
      par_type_l <= par_type_l_n;
      stop_l     <= stop_l_n;
      stop_idx   <= stop_idx_n;
      shift      <= shift_n;
      par_acc    <= par_acc_n;
      zero_acc   <= zero_acc_n;
      ferr_acc   <= ferr_acc_n;
      brk_acc    <= brk_acc_n;
      m_data     <= m_data_n;
      m_valid    <= m_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
      break_det  <= break_det_n;
      overrun    <= overrun_n;
      busy       <= busy_n;
    end
  end

  // Frame sequencing, per-bit accumulation and output handshake
  always_comb begin
    state_n      = state;
    cnt_n        = cnt + DIV_W'(1);
    samp_lo_n    = samp_lo;
    samp_mid_n   = samp_mid;
    div_l_n      = div_l;
    len_l_n      = len_l;
    bit_idx_n    = bit_idx;
    par_en_l_n   = par_en_l;
    par_type_l_n = par_type_l;
    stop_l_n     = stop_l;
    stop_idx_n   = stop_idx;
    shift_n      = shift;
    par_acc_n    = par_acc;
    zero_acc_n   = zero_acc;
    ferr_acc_n   = ferr_acc;
    brk_acc_n    = brk_acc;
    m_data_n     = m_data;
    m_valid_n    = m_valid;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;
    break_det_n  = break_det;
    overrun_n    = overrun;
    done_c       = 1'b0;

    if (cnt == mid_m1_c) samp_lo_n  = rx_s;
    if (cnt == mid_c)    samp_mid_n = rx_s;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (en && fall_c) begin
          state_n      = START;
          div_l_n      = div;
          len_l_n      = len_clamp_c;
          par_en_l_n   = parity_en;
          par_type_l_n = parity_type;
          stop_l_n     = stop_bits;
          stop_idx_n   = 1'b0;
          bit_idx_n    = '0;
          shift_n      = '0;
          par_acc_n    = 1'b0;
          zero_acc_n   = 1'b1;
          ferr_acc_n   = 1'b0;
          brk_acc_n    = 1'b0;
        end
      end
      START: begin
        if (at_vote_c && vote_c) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (at_end_c) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (at_vote_c) begin
          shift_n    = shift | (DATA_W'(vote_c) << bit_idx);
          par_acc_n  = par_acc ^ vote_c;
          zero_acc_n = zero_acc & ~vote_c;
        end
        if (at_end_c) begin
          cnt_n = '0;
          if (bit_idx == len_l - LEN_W'(1)) state_n = par_en_l ? PARITY : STOP;
          else                              bit_idx_n = bit_idx + LEN_W'(1);
        end
      end
      PARITY: begin
        if (at_vote_c) begin
          par_acc_n  = par_acc ^ vote_c;
          zero_acc_n = zero_acc & ~vote_c;
        end
        if (at_end_c) begin
          state_n = STOP;
          cnt_n   = '0;
        end
      end
      STOP: begin
        // Only the first stop bit is sampled except in 2-stop mode
        if (at_vote_c && (!stop_idx || stop_l == 2'd1)) ferr_acc_n = ferr_acc | ~vote_c;
        if (at_vote_c && !stop_idx)                     brk_acc_n  = zero_acc & ~vote_c;
        if (!stop_idx) done_c = at_vote_c && (stop_l != 2'd1) && (stop_l != 2'd2);
        else           done_c = (stop_l == 2'd1) ? at_vote_c : (cnt == mid_c);
        if (done_c) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (at_end_c) begin
          stop_idx_n = 1'b1;
          cnt_n      = '0;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      done_c  = 1'b0;
    end

    if (done_c) begin
      if (!m_valid || m_ready) begin
        m_valid_n    = 1'b1;
        m_data_n     = shift_n;
        parity_err_n = par_en_l & (par_acc_n ^ par_type_l);
        frame_err_n  = ferr_acc_n | brk_acc_n;
        break_det_n  = brk_acc_n;
      end else begin
        overrun_n = 1'b1;
      end
    end else if (accept_c) begin
      m_valid_n = 1'b0;
      overrun_n = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: directed scenarios plus randomized
// back-to-back frames compared against a frame-level reference model.
module tb_uart_rx_param;
  logic        clk = 1'b0;
  logic        rst_n, rx, en;
  logic [15:0] div;
  logic [3:0]  data_len;
  logic        parity_en, parity_type;
  logic [1:0]  stop_bits;
  logic [7:0]  m_data;
  logic        m_valid, m_ready, parity_err, frame_err, break_det, overrun, busy;

  int total = 0;
  int bad   = 0;
  logic        line_q[$];
  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  bit          cap_en = 1'b0;

  uart_rx_param #(.CLK_HZ(25000000), .DIV_W(16), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .en(en), .div(div), .data_len(data_len),
    .parity_en(parity_en), .parity_type(parity_type), .stop_bits(stop_bits),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .parity_err(parity_err),
    .frame_err(frame_err), .break_det(break_det), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (cap_en && m_valid && m_ready) got_q.push_back({m_data, parity_err, frame_err, break_det});

  initial begin
    #5000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Expected {data, parity_err, frame_err, break_det} for one frame as sent on the line
  function automatic logic [10:0] model_frame(input logic [7:0] data, input int len, input bit pen,
                                              input bit ptype, input bit pbit, input int mode,
                                              input bit s0, input bit s1);
    logic [7:0] dm;
    logic perr, ferr, brk;
    dm   = data & 8'((1 << len) - 1);
    perr = pen && (((^dm) ^ pbit) != ptype);
    brk  = (dm == 8'h00) && (!pen || !pbit) && !s0;
    ferr = !s0 || (mode == 1 && !s1) || brk;
    return {dm, perr, ferr, brk};
  endfunction

  function automatic int clamp_len(input int raw);
    return (raw < 5) ? 5 : (raw > 8) ? 8 : raw;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic add_bit(input logic v, input int d, input bit spike);
    for (int c = 0; c <= d; c++) line_q.push_back((spike && c == (d >> 1) + 1) ? ~v : v);
  endtask

  task automatic build_frame(input logic [7:0] data, input int len, input bit pen, input bit pbit,
                             input int mode, input bit s0, input bit s1, input int d, input bit spike);
    add_bit(1'b0, d, 1'b0);
    for (int j = 0; j < len; j++) add_bit(data[j], d, spike);
    if (pen) add_bit(pbit, d, 1'b0);
    add_bit(s0, d, 1'b0);
    if (mode == 1)      add_bit(s1, d, 1'b0);
    else if (mode == 2) add_bit(1'b1, d, 1'b0);
  endtask

  task automatic drive_line(input int max_cycles);
    int n;
    n = 0;
    while (line_q.size() > 0 && n < max_cycles) begin
      @(negedge clk);
      rx = line_q.pop_front();
      n++;
    end
    line_q.delete();
  endtask

  task automatic set_cfg(input int d, input int len, input bit pen, input bit pt, input int sb);
    div = 16'(d); data_len = 4'(len); parity_en = pen; parity_type = pt; stop_bits = 2'(sb);
  endtask

  task automatic accept_word();
    @(negedge clk); m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; en = 1'b1; m_ready = 1'b0;
    set_cfg(24, 8, 0, 0, 0);
    wait_cycles(3);
    total++;
    if ({m_valid, parity_err, frame_err, break_det, overrun, busy, m_data} !== 14'h0) begin
      bad++; $display("FAIL reset_hold got=%b exp=0", {m_valid, parity_err, frame_err, break_det, overrun, busy, m_data});
    end
    rst_n = 1'b1;
    wait_cycles(5);
    total++;
    if ({m_valid, overrun, busy} !== 3'b000) begin
      bad++; $display("FAIL reset_release got=%b exp=000", {m_valid, overrun, busy});
    end
  endtask

  task automatic test_latency();
    int n;
    set_cfg(24, 8, 0, 0, 0);
    build_frame(8'hA5, 8, 0, 0, 0, 1, 1, 24, 0);
    fork
      drive_line(100000);
      begin
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); n++; end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL latency_busy got=%b exp=1", busy); end
        n = 0;
        while (!m_valid && n < 1000) begin @(negedge clk); n++; end
        total++;
        if (n !== 239) begin bad++; $display("FAIL latency_cycles got=%0d exp=239", n); end
      end
    join
    wait_cycles(5);
    total++;
    if (m_data !== 8'hA5) begin bad++; $display("FAIL latency_data got=%h exp=a5", m_data); end
    total++;
    if ({parity_err, frame_err, break_det, overrun} !== 4'b0) begin
      bad++; $display("FAIL latency_flags got=%b exp=0000", {parity_err, frame_err, break_det, overrun});
    end
    accept_word();
  endtask

  task automatic test_parity();
    set_cfg(24, 7, 1, 0, 1);
    build_frame(8'h55, 7, 1, 1'b1, 1, 1, 1, 24, 0);
    drive_line(100000);
    wait_cycles(5);
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'h55}) begin
      bad++; $display("FAIL parity_data got=%b/%h exp=1/55", m_valid, m_data);
    end
    total++;
    if ({parity_err, frame_err, break_det} !== 3'b100) begin
      bad++; $display("FAIL parity_flags got=%b exp=100", {parity_err, frame_err, break_det});
    end
    accept_word();
  endtask

  task automatic test_glitch();
    set_cfg(24, 8, 0, 0, 0);
    @(negedge clk); rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(60);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL glitch_valid got=%b exp=0", m_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy got=%b exp=0", busy); end
  endtask

  task automatic test_overrun();
    set_cfg(24, 8, 0, 0, 0);
    build_frame(8'h11, 8, 0, 0, 0, 1, 1, 24, 0);
    build_frame(8'h22, 8, 0, 0, 0, 1, 1, 24, 0);
    drive_line(100000);
    wait_cycles(5);
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'h11}) begin
      bad++; $display("FAIL overrun_held got=%b/%h exp=1/11", m_valid, m_data);
    end
    total++;
    if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    accept_word();
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL overrun_accept_valid got=%b exp=0", m_valid); end
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_break();
    set_cfg(24, 8, 0, 0, 0);
    for (int i = 0; i < 12; i++) add_bit(1'b0, 24, 1'b0);
    drive_line(100000);
    total++;
    if ({m_valid, m_data} !== {1'b1, 8'h00}) begin
      bad++; $display("FAIL break_data got=%b/%h exp=1/00", m_valid, m_data);
    end
    total++;
    if ({parity_err, frame_err, break_det} !== 3'b011) begin
      bad++; $display("FAIL break_flags got=%b exp=011", {parity_err, frame_err, break_det});
    end
    accept_word();
    wait_cycles(75);
    total++;
    if ({m_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL break_hold_low got=%b exp=00", {m_valid, busy});
    end
    rx = 1'b1;
    wait_cycles(25);
    build_frame(8'h3C, 8, 0, 0, 0, 1, 1, 24, 0);
    drive_line(100000);
    wait_cycles(5);
    total++;
    if ({m_valid, m_data, parity_err, frame_err, break_det} !== {1'b1, 8'h3C, 3'b000}) begin
      bad++; $display("FAIL break_recover got=%b/%h/%b exp=1/3c/000", m_valid, m_data, {parity_err, frame_err, break_det});
    end
    accept_word();
  endtask

  task automatic test_spike();
    logic [7:0] d;
    d = 8'($urandom);
    set_cfg(24, 8, 1, 0, 0);
    build_frame(d, 8, 1, ^d, 0, 1, 1, 24, 1);
    drive_line(100000);
    wait_cycles(5);
    total++;
    if ({m_valid, m_data} !== {1'b1, d}) begin
      bad++; $display("FAIL spike_data got=%b/%h exp=1/%h", m_valid, m_data, d);
    end
    total++;
    if ({parity_err, frame_err, break_det} !== 3'b000) begin
      bad++; $display("FAIL spike_flags got=%b exp=000", {parity_err, frame_err, break_det});
    end
    accept_word();
  endtask

  task automatic test_enable_abort();
    set_cfg(24, 8, 0, 0, 0);
    build_frame(8'h6B, 8, 0, 0, 0, 1, 1, 24, 0);
    drive_line(100000);
    wait_cycles(5);
    build_frame(8'h0F, 8, 0, 0, 0, 1, 1, 24, 0);
    drive_line(120);
    @(negedge clk); en = 1'b0; rx = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++;
    if ({m_valid, m_data, overrun} !== {1'b1, 8'h6B, 1'b0}) begin
      bad++; $display("FAIL abort_held got=%b/%h/%b exp=1/6b/0", m_valid, m_data, overrun);
    end
    en = 1'b1;
    wait_cycles(60);
    total++;
    if ({m_valid, m_data, busy} !== {1'b1, 8'h6B, 1'b0}) begin
      bad++; $display("FAIL abort_after got=%b/%h/%b exp=1/6b/0", m_valid, m_data, busy);
    end
  endtask

  task automatic test_reset_midframe();
    set_cfg(24, 8, 0, 0, 0);
    build_frame(8'hC3, 8, 0, 0, 0, 1, 1, 24, 0);
    drive_line(150);
    @(negedge clk); rst_n = 1'b0;
    #1;
    total++;
    if ({m_valid, parity_err, frame_err, break_det, overrun, busy, m_data} !== 14'h0) begin
      bad++; $display("FAIL rstmid_outputs got=%b exp=0", {m_valid, parity_err, frame_err, break_det, overrun, busy, m_data});
    end
    rx = 1'b1;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(60);
    total++;
    if ({m_valid, busy} !== 2'b00) begin
      bad++; $display("FAIL rstmid_idle got=%b exp=00", {m_valid, busy});
    end
    build_frame(8'h96, 8, 0, 0, 0, 1, 1, 24, 0);
    drive_line(100000);
    wait_cycles(5);
    total++;
    if ({m_valid, m_data, parity_err, frame_err, break_det} !== {1'b1, 8'h96, 3'b000}) begin
      bad++; $display("FAIL rstmid_next got=%b/%h/%b exp=1/96/000", m_valid, m_data, {parity_err, frame_err, break_det});
    end
    accept_word();
  endtask

  task automatic test_back_to_back();
    int d, raw, len, mode;
    bit pen, pt, badp, s0, s1, pbit, last;
    logic [7:0] data, dm;
    exp_q.delete(); got_q.delete();
    m_ready = 1'b1;
    @(negedge clk); cap_en = 1'b1;
    for (int i = 0; i < 25; i++) begin
      d    = int'($urandom_range(3, 20));
      raw  = int'($urandom_range(0, 15));
      len  = clamp_len(raw);
      pen  = 1'($urandom_range(0, 1));
      pt   = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      badp = ($urandom_range(0, 3) == 0);
      s0   = ($urandom_range(0, 5) != 0);
      s1   = ($urandom_range(0, 5) != 0);
      data = 8'($urandom);
      if ($urandom_range(0, 7) == 0) data = 8'h00;
      dm   = data & 8'((1 << len) - 1);
      pbit = (^dm) ^ pt ^ badp;
      set_cfg(d, raw, pen, pt, mode);
      build_frame(data, len, pen, pbit, mode, s0, s1, d, 1'b0);
      last = (mode == 1) ? s1 : (mode == 2) ? 1'b1 : s0;
      if (!last || $urandom_range(0, 1) == 0) add_bit(1'b1, d, 1'b0);
      exp_q.push_back(model_frame(data, len, pen, pt, pbit, mode, s0, s1));
      drive_line(100000);
    end
    wait_cycles(50);
    cap_en = 1'b0;
    m_ready = 1'b0;
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      total++;
      if (got_q[i] !== exp_q[i]) begin
        bad++; $display("FAIL b2b_frame%0d got=%h/%b exp=%h/%b", i, got_q[i][10:3], got_q[i][2:0], exp_q[i][10:3], exp_q[i][2:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_parity();
    test_glitch();
    test_overrun();
    test_break();
    test_spike();
    test_enable_abort();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
